// File: rtl/frame_writer.sv
// Frame writer: places the interior pixel stream of a 3x3 filter stage at its raster position
// in a full-size frame memory. Optional border zero-fill sweep when BORDER_CLEAR_EN is defined.
module frame_writer #(
  parameter int unsigned IMG_W  = 512,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned BORDER = 1,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              pixel_in_valid,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [PIX_W-1:0]  mem_wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun_err
);

  localparam int unsigned COL_W     = $clog2(IMG_W);
  localparam int unsigned ROW_W     = $clog2(IMG_H);
  localparam int unsigned IN_W      = IMG_W - 2 * BORDER;
  localparam int unsigned IN_H      = IMG_H - 2 * BORDER;
  localparam int unsigned PTR_START = BORDER * IMG_W + BORDER;
  localparam int unsigned ROW_STEP  = 2 * BORDER + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
`ifdef BORDER_CLEAR_EN
    ST_CLEAR   = 2'd2,
`endif
    ST_DONE    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic last_pix, row_end;
  assign row_end  = (col_q == COL_W'(IN_W - 1));
  assign last_pix = row_end && (row_q == ROW_W'(IN_H - 1));

`ifdef BORDER_CLEAR_EN
  logic clr_last, clr_mid_row;
  assign clr_last    = (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));
  assign clr_mid_row = (row_q >= ROW_W'(BORDER)) && (row_q < ROW_W'(IMG_H - BORDER));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_CAPTURE;
      ST_CAPTURE: if (pixel_in_valid && last_pix) begin
`ifdef BORDER_CLEAR_EN
        state_d = ST_CLEAR;
`else
        state_d = ST_DONE;
`endif
      end
`ifdef BORDER_CLEAR_EN
      ST_CLEAR:   if (clr_last) state_d = ST_DONE;
`endif
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; status outputs trail the state by one cycle
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    done_d  = (state_q == ST_DONE);
`ifdef BORDER_CLEAR_EN
    busy_d  = (state_q == ST_CAPTURE) || (state_q == ST_CLEAR);
`else
    busy_d  = (state_q == ST_CAPTURE);
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d = ADDR_W'(PTR_START);
          col_d = '0;
          row_d = '0;
          ovr_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (pixel_in_valid) begin
          wr_en_d = 1'b1;
          addr_d  = ptr_q;
          data_d  = pixel_in;
`ifdef BORDER_CLEAR_EN
          if (last_pix) begin
            col_d = '0;
            row_d = '0;
            ptr_d = '0;
          end else
`endif
          if (row_end) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
            ptr_d = ptr_q + ADDR_W'(ROW_STEP);
          end else begin
            col_d = col_q + COL_W'(1);
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
`ifdef BORDER_CLEAR_EN
      ST_CLEAR: begin
        wr_en_d = 1'b1;
        addr_d  = ptr_q;
        data_d  = '0;
        if (col_q == COL_W'(IMG_W - 1)) begin
          col_d = '0;
          row_d = row_q + ROW_W'(1);
          ptr_d = ptr_q + ADDR_W'(1);
        end else if (clr_mid_row && (col_q == COL_W'(BORDER - 1))) begin
          // skip the interior span of a middle row
          col_d = COL_W'(IMG_W - BORDER);
          ptr_d = ptr_q + ADDR_W'(IN_W + 1);
        end else begin
          col_d = col_q + COL_W'(1);
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
`endif
      default: ;
    endcase
    if (pixel_in_valid && (state_q != ST_CAPTURE)) ovr_d = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun_err = ovr_q;

endmodule
